// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for an N-digit common-anode
// seven-segment display.
// - Digits are scanned one at a time. Each digit stays lit for SCAN_DIV cycles.
// - The anode (an) and segment (seg) lines are active-low.
// - A new value is transferred to the display only at the frame boundary.
//   This prevents a number from tearing partway through a scan.
// Optional build macro: SEVEN_SEG_LZB_EN enables leading-zero blanking.
module seven_seg_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    output logic                    pending,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DIV_WIDTH-1:0]    div;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] disp;
    logic [4*NUM_DIGITS-1:0] pend;

    logic                    tick;
    logic                    boundary;
    logic [3:0]              cur_nib;
    logic [6:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   lz;
    logic                    blank;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_next;

    assign tick     = (div == DIV_WIDTH'(SCAN_DIV - 1));
    assign boundary = tick && (idx == IDX_W'(NUM_DIGITS - 1));
    assign cur_nib  = disp[4*int'(idx) +: 4];

    // Decode the current digit's nibble into the active-low {A..G} pattern.
    always_comb begin
        dec_seg = 7'b1111111;
        case (cur_nib)
            4'h0: dec_seg = 7'b0000001;
            4'h1: dec_seg = 7'b1001111;
            4'h2: dec_seg = 7'b0010010;
            4'h3: dec_seg = 7'b0000110;
            4'h4: dec_seg = 7'b1001100;
            4'h5: dec_seg = 7'b0100100;
            4'h6: dec_seg = 7'b0100000;
            4'h7: dec_seg = 7'b0001111;
            4'h8: dec_seg = 7'b0000000;
            4'h9: dec_seg = 7'b0000100;
            4'hA: dec_seg = 7'b0001000;
            4'hB: dec_seg = 7'b1100000;
            4'hC: dec_seg = 7'b0110001;
            4'hD: dec_seg = 7'b1000010;
            4'hE: dec_seg = 7'b0110000;
            4'hF: dec_seg = 7'b0111000;
            default: dec_seg = 7'b1111111;
        endcase
    end

    // lz[i] is set when digit i and every digit above it are zero.
    // Digit 0 is never blanked, so lz[0] is always clear.
    always_comb begin
        lz = '0;
`ifdef SEVEN_SEG_LZB_EN
        lz[NUM_DIGITS-1] = (disp[4*(NUM_DIGITS-1) +: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 1; i--) begin
            lz[i] = lz[i+1] && (disp[4*i +: 4] == 4'h0);
        end
`endif
    end

    // Next-cycle anode and segment values for the digit currently selected.
    always_comb begin
        blank    = lz[idx];
        an_next  = ~(NUM_DIGITS'(1) << idx);
        seg_next = dec_seg;
        if (blank) begin
            an_next  = '1;
            seg_next = 7'b1111111;
        end
    end

    // Prescaler, digit scan, frame-synchronous load, and registered pin drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            div     <= '0;
            idx     <= '0;
            disp    <= '0;
            pend    <= '0;
            pending <= 1'b0;
            an      <= '1;
            seg     <= 7'b1111111;
        end else begin
            if (tick) begin
                div <= '0;
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                div <= div + 1'b1;
            end

            if (load && boundary) begin
                // A load on the boundary cycle goes straight to the display.
                disp    <= value;
                pend    <= value;
                pending <= 1'b0;
            end else if (load) begin
                pend    <= value;
                pending <= 1'b1;
            end else if (boundary && pending) begin
                disp    <= pend;
                pending <= 1'b0;
            end

            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Testbench for seven_seg_scanner (NUM_DIGITS=4, SCAN_DIV=4).
// - Applies directed steps followed by random loads and resets.
// - Checks the DUT against a cycle-count-based reference model.
// - Expected values follow SEVEN_SEG_LZB_EN when that macro is defined.
module tb_seven_seg_scanner;

    localparam int N = 4;
    localparam int S = 4;
    localparam int FRAME = N * S;

    logic          clk = 1'b0;
    logic          reset;
    logic          load;
    logic [15:0]   value;
    logic          pending;
    logic [N-1:0]  an;
    logic [6:0]    seg;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: cycles since reset, displayed value, queued value.
    int            m_t;
    logic [15:0]   m_disp;
    logic [15:0]   m_pendv;
    logic          m_pending;
    logic [6:0]    seg_tab [16];

    seven_seg_scanner #(.NUM_DIGITS(N), .SCAN_DIV(S), .DIV_WIDTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .value   (value),
        .pending (pending),
        .an      (an),
        .seg     (seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, m_t);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        value = '0;
        @(posedge clk);
        #1;
        m_t = 0; m_disp = '0; m_pendv = '0; m_pending = 1'b0;
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_pending", 32'(pending), 32'h0);
        reset = 1'b0;
    endtask

    task automatic step(input logic ld, input logic [15:0] v);
        int          d;
        logic [15:0] upper;
        logic        blank;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        logic        bnd;
        load  = ld;
        value = v;
        d     = (m_t / S) % N;
        upper = m_disp >> (4 * d);
        blank = 1'b0;
`ifdef SEVEN_SEG_LZB_EN
        blank = (d >= 1) && (upper == 16'h0);
`endif
        exp_an  = blank ? 4'hF : 4'(4'hF ^ (1 << d));
        exp_seg = blank ? 7'h7F : seg_tab[upper[3:0]];
        bnd = (m_t % FRAME) == FRAME - 1;
        if (ld && bnd) begin
            m_disp = v; m_pendv = v; m_pending = 1'b0;
        end else if (ld) begin
            m_pendv = v; m_pending = 1'b1;
        end else if (bnd && m_pending) begin
            m_disp = m_pendv; m_pending = 1'b0;
        end
        m_t++;
        @(posedge clk);
        #1;
        chk("an", 32'(an), 32'(exp_an));
        chk("seg", 32'(seg), 32'(exp_seg));
        chk("pending", 32'(pending), 32'(m_pending));
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0);
    endtask

    // Advance until the next stepped cycle is at the given frame phase.
    task automatic to_phase(input int ph);
        for (int i = 0; i < FRAME && (m_t % FRAME) != ph; i++) step(1'b0, 16'h0);
    endtask

    initial begin
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        m_t = 0; m_disp = '0; m_pendv = '0; m_pending = 1'b0;
        reset = 1'b1; load = 1'b0; value = '0;

        // Check the reset values, then let the display scan zeros.
        do_reset();
        idle(20);

        // Load a value in the middle of a frame.
        to_phase(5);
        step(1'b1, 16'h1A3F);
        idle(2 * FRAME);

        // Load twice in one frame; only the second value is displayed.
        to_phase(2);
        step(1'b1, 16'h1234);
        idle(3);
        step(1'b1, 16'h5678);
        idle(2 * FRAME);

        // Load exactly on the boundary cycle (bypass path).
        to_phase(FRAME - 1);
        step(1'b1, 16'hBEEF);
        idle(2 * FRAME);

        // Assert reset while a load is pending during the digit-2 slot.
        to_phase(9);
        step(1'b1, 16'h9876);
        step(1'b0, 16'h0);
        do_reset();
        idle(2 * FRAME);

        // Values with leading zeros.
        step(1'b1, 16'h0040);
        idle(2 * FRAME);
        step(1'b1, 16'h0000);
        idle(2 * FRAME);
        step(1'b1, 16'h0305);
        idle(2 * FRAME);

        // Random loads and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else if ($urandom_range(5) == 0) begin
                logic [15:0] rv;
                rv = 16'($urandom);
                if ($urandom_range(2) == 0) rv = rv & 16'h00FF;
                step(1'b1, rv);
            end else begin
                step(1'b0, 16'h0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
